// File: rtl/mips_pkg.sv
// mips_pkg: shared control-field bit positions, ALU/funct codes and multiplier FSM states
package mips_pkg;
  localparam int WB_REG_WRITE = 1;
  localparam int MEM_READ = 1;
  localparam int EX_REG_DST = 3;
  localparam int EX_ALU_OP_HI = 2;
  localparam int EX_ALU_OP_LO = 1;
  localparam int EX_ALU_SRC = 0;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
  function automatic logic is_multu(input logic [1:0] alu_op, input logic [5:0] funct);
    return alu_op == ALU_FUNCT && funct == F_MULTU;
  endfunction
endpackage

// File: rtl/mult_iter.sv
// mult_iter: iterative 32x32->64 unsigned shift-add multiplier, one partial product per cycle
module mult_iter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        idle,
  output logic        busy,
  output logic        wr,
  output logic [63:0] prod
);
  mul_state_t state;
  logic [4:0] count;
  logic [63:0] mcand;
  logic [63:0] acc;
  logic [31:0] mplier;
  assign idle = state == MUL_IDLE;
  assign busy = state == MUL_BUSY;
  assign wr = busy && count == 5'd31;
  // prod is the accumulator after this cycle's step; on the last step it is the full product
  assign prod = acc + (mplier[0] ? mcand : 64'd0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= MUL_IDLE;
      count <= '0;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
    end else
      case (state)
        MUL_IDLE: if (start) begin
          state <= MUL_BUSY;
          count <= '0;
          mcand <= {32'd0, a};
          mplier <= b;
          acc <= '0;
        end
        MUL_BUSY: begin
          acc <= prod;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          count <= count + 5'd1;
          if (wr) state <= MUL_DONE;
        end
        default: state <= MUL_IDLE;
      endcase
endmodule

// File: rtl/execute.sv
// execute: MIPS EX stage with ALU, branch target, HI/LO and iterative multu feeding the EX/MEM latch
// EXECUTE_FWD_EN adds EX/MEM and MEM/WB operand forwarding
module execute
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  id_ex_wb,
  input  logic [2:0]  id_ex_mem,
  input  logic [3:0]  id_ex_execute,
  input  logic [31:0] id_ex_npc,
  input  logic [31:0] id_ex_readdat1,
  input  logic [31:0] id_ex_readdat2,
  input  logic [31:0] id_ex_sign_ext,
  input  logic [4:0]  id_ex_instr_bits_20_16,
  input  logic [4:0]  id_ex_instr_bits_15_11,
  output logic [1:0]  ex_mem_wb,
  output logic [2:0]  ex_mem_mem,
  output logic [31:0] ex_mem_add_result,
  output logic        ex_mem_zero,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_readdat2,
  output logic [4:0]  ex_mem_dest_reg,
  output logic        ex_stall
`ifdef EXECUTE_FWD_EN
  ,
  input  logic [4:0]  id_ex_instr_bits_25_21,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg_location,
  input  logic [31:0] mem_wb_write_data
`endif
);
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [1:0] alu_op;
  logic [31:0] a;
  logic [31:0] rt_val;
  logic [31:0] b;
  logic [31:0] alu;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] prod;
  logic multu;
  logic idle;
  logic busy;
  logic wr;
  logic bubble;
  assign funct = id_ex_sign_ext[5:0];
  assign shamt = id_ex_sign_ext[10:6];
  assign alu_op = id_ex_execute[EX_ALU_OP_HI:EX_ALU_OP_LO];
  assign multu = is_multu(alu_op, funct);
`ifdef EXECUTE_FWD_EN
  logic ex_fwd_ok;
  logic wb_fwd_ok;
  // loads in EX/MEM have no data yet, so only ALU producers forward from there
  assign ex_fwd_ok = ex_mem_wb[WB_REG_WRITE] && !ex_mem_mem[MEM_READ] && ex_mem_dest_reg != 5'd0;
  assign wb_fwd_ok = wb_reg_write && wb_write_reg_location != 5'd0;
  assign a = ex_fwd_ok && ex_mem_dest_reg == id_ex_instr_bits_25_21 ? ex_mem_alu_result :
             wb_fwd_ok && wb_write_reg_location == id_ex_instr_bits_25_21 ? mem_wb_write_data :
             id_ex_readdat1;
  assign rt_val = ex_fwd_ok && ex_mem_dest_reg == id_ex_instr_bits_20_16 ? ex_mem_alu_result :
                  wb_fwd_ok && wb_write_reg_location == id_ex_instr_bits_20_16 ? mem_wb_write_data :
                  id_ex_readdat2;
`else
  assign a = id_ex_readdat1;
  assign rt_val = id_ex_readdat2;
`endif
  assign b = id_ex_execute[EX_ALU_SRC] ? id_ex_sign_ext : rt_val;
  always_comb begin
    alu = 32'd0;
    if (alu_op == ALU_ADD) alu = a + b;
    else if (alu_op == ALU_SUB) alu = a - b;
    else if (alu_op == ALU_FUNCT)
      case (funct)
        F_ADD: alu = a + b;
        F_SUB: alu = a - b;
        F_AND: alu = a & b;
        F_OR: alu = a | b;
        F_NOR: alu = ~(a | b);
        F_SLT: alu = {31'd0, $signed(a) < $signed(b)};
        F_SLL: alu = b << shamt;
        F_SRL: alu = b >> shamt;
        F_MFHI: alu = hi;
        F_MFLO: alu = lo;
        default: alu = 32'd0;
      endcase
  end
  mult_iter u_mult (
    .clk(clk),
    .rst(rst),
    .start(multu),
    .a(a),
    .b(rt_val),
    .idle(idle),
    .busy(busy),
    .wr(wr),
    .prod(prod)
  );
  // gated by rst so the stall drops the moment reset is asserted
  assign ex_stall = rst && ((idle && multu) || busy);
  // multu itself never writes a GPR, so it retires as a bubble in its DONE cycle
  assign bubble = ex_stall || multu;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hi <= '0;
      lo <= '0;
      ex_mem_wb <= '0;
      ex_mem_mem <= '0;
      ex_mem_add_result <= '0;
      ex_mem_zero <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_readdat2 <= '0;
      ex_mem_dest_reg <= '0;
    end else begin
      if (wr) {hi, lo} <= prod;
      ex_mem_wb <= bubble ? 2'b00 : id_ex_wb;
      ex_mem_mem <= bubble ? 3'b000 : id_ex_mem;
      ex_mem_add_result <= id_ex_npc + {id_ex_sign_ext[29:0], 2'b00};
      ex_mem_zero <= alu == 32'd0;
      ex_mem_alu_result <= alu;
      ex_mem_readdat2 <= rt_val;
      ex_mem_dest_reg <= id_ex_execute[EX_REG_DST] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: vector table, hand sequences for multu/reset/forwarding, and randomized ops against a reference model
module tb_execute;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] id_ex_wb;
  logic [2:0] id_ex_mem;
  logic [3:0] id_ex_execute;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_readdat1;
  logic [31:0] id_ex_readdat2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0] id_ex_instr_bits_20_16;
  logic [4:0] id_ex_instr_bits_15_11;
  logic [1:0] ex_mem_wb;
  logic [2:0] ex_mem_mem;
  logic [31:0] ex_mem_add_result;
  logic ex_mem_zero;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_readdat2;
  logic [4:0] ex_mem_dest_reg;
  logic ex_stall;
`ifdef EXECUTE_FWD_EN
  logic [4:0] id_ex_instr_bits_25_21;
  logic wb_reg_write;
  logic [4:0] wb_write_reg_location;
  logic [31:0] mem_wb_write_data;
`endif
  execute dut (
    .clk(clk),
    .rst(rst),
    .id_ex_wb(id_ex_wb),
    .id_ex_mem(id_ex_mem),
    .id_ex_execute(id_ex_execute),
    .id_ex_npc(id_ex_npc),
    .id_ex_readdat1(id_ex_readdat1),
    .id_ex_readdat2(id_ex_readdat2),
    .id_ex_sign_ext(id_ex_sign_ext),
    .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16),
    .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
    .ex_mem_wb(ex_mem_wb),
    .ex_mem_mem(ex_mem_mem),
    .ex_mem_add_result(ex_mem_add_result),
    .ex_mem_zero(ex_mem_zero),
    .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_readdat2(ex_mem_readdat2),
    .ex_mem_dest_reg(ex_mem_dest_reg),
    .ex_stall(ex_stall)
`ifdef EXECUTE_FWD_EN
    ,
    .id_ex_instr_bits_25_21(id_ex_instr_bits_25_21),
    .wb_reg_write(wb_reg_write),
    .wb_write_reg_location(wb_write_reg_location),
    .mem_wb_write_data(mem_wb_write_data)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [31:0] res;
    logic [31:0] addr;
    logic zero;
    logic [4:0] dest;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                       input logic [31:0] npc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] se, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    id_ex_wb = wb;
    id_ex_mem = mem;
    id_ex_execute = ex;
    id_ex_npc = npc;
    id_ex_readdat1 = a;
    id_ex_readdat2 = b;
    id_ex_sign_ext = se;
    id_ex_instr_bits_20_16 = rt;
    id_ex_instr_bits_15_11 = rd;
`ifdef EXECUTE_FWD_EN
    id_ex_instr_bits_25_21 = rs;
`else
    if (rs != 5'd0) id_ex_npc = npc;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference ALU: what each opcode means, with HI/LO taken from the model's own 64-bit product
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic src, input logic [31:0] a,
                                          input logic [31:0] rtv, input logic [31:0] se);
    logic [31:0] b;
    b = src ? se : rtv;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10:
        case (se[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: return b << se[10:6];
          6'h02: return b >> se[10:6];
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return 32'd0;
        endcase
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_multu(input logic [31:0] a, input logic [31:0] b);
    int n;
    {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
    drive(2'b10, 3'b000, 4'b1100, 32'h0, a, b, 32'h00000019, 5'd1, 5'd2, 5'd0);
    #1;
    n = 0;
    while (ex_stall === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      chk("stall_bubble", {27'd0, ex_mem_wb, ex_mem_mem}, 32'd0);
    end
    chk("stall_len", n, 32'd33);
    step();
    chk("multu_retire", {27'd0, ex_mem_wb, ex_mem_mem}, 32'd0);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h00000010, 5'd0, 5'd0, 5'd7);
    step();
    chk("mfhi", ex_mem_alu_result, m_hi);
    chk("mfhi_wb", {30'd0, ex_mem_wb}, 32'd2);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h00000012, 5'd0, 5'd0, 5'd7);
    step();
    chk("mflo", ex_mem_alu_result, m_lo);
  endtask

  logic [5:0] fl[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h10, 6'h12, 6'h3F};

  initial begin
    v[0] = '{2'b10, 3'b000, 4'b1100, 32'h4, 32'h11121951, 32'h23938222, 32'h1820, 5'd2, 5'd3, 32'h34A59B73, 32'h6084, 1'b0, 5'd3};
    v[1] = '{2'b00, 3'b100, 4'b0010, 32'h10, 32'h55, 32'h55, 32'hFFFFFFFF, 5'd5, 5'd31, 32'h0, 32'hC, 1'b1, 5'd5};
    v[2] = '{2'b11, 3'b010, 4'b0001, 32'h20, 32'h11121951, 32'hABCD, 32'h8, 5'd4, 5'd0, 32'h11121959, 32'h40, 1'b0, 5'd4};
    v[3] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h202A, 5'd1, 5'd4, 32'h1, 32'h80A8, 1'b0, 5'd4};
    v[4] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'h12345678, 32'h3, 32'h3100, 5'd1, 5'd6, 32'h30, 32'hC400, 1'b0, 5'd6};
    v[5] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h80000000, 32'h3FC2, 5'd1, 5'd7, 32'h1, 32'hFF08, 1'b0, 5'd7};
    v[6] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'h0F0F0000, 32'h00F0F000, 32'h4027, 5'd1, 5'd8, 32'hF0000FFF, 32'h1009C, 1'b0, 5'd8};
    v[7] = '{2'b10, 3'b000, 4'b1100, 32'h0, 32'h1, 32'h2, 32'h483F, 5'd1, 5'd9, 32'h0, 32'h120FC, 1'b1, 5'd9};
    v[8] = '{2'b10, 3'b000, 4'b0010, 32'h100, 32'h0, 32'h1, 32'h0, 5'd10, 5'd0, 32'hFFFFFFFF, 32'h100, 1'b0, 5'd10};
    rst = 1'b0;
`ifdef EXECUTE_FWD_EN
    wb_reg_write = 1'b0;
    wb_write_reg_location = 5'd0;
    mem_wb_write_data = 32'd0;
`endif
    drive(2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("rst_stall", {31'd0, ex_stall}, 32'd0);
    chk("rst_ctrl", {27'd0, ex_mem_wb, ex_mem_mem}, 32'd0);
    chk("rst_alu", ex_mem_alu_result, 32'd0);
    chk("rst_add", ex_mem_add_result, 32'd0);
    chk("rst_misc", {ex_mem_readdat2[26:0], ex_mem_dest_reg} | {31'd0, ex_mem_zero}, 32'd0);
    #11;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].wb, v[i].mem, v[i].ex, v[i].npc, v[i].a, v[i].b, v[i].se, 5'd0, v[i].rt, v[i].rd);
      step();
      chk($sformatf("vec%0d_res", i), ex_mem_alu_result, v[i].res);
      chk($sformatf("vec%0d_addr", i), ex_mem_add_result, v[i].addr);
      chk($sformatf("vec%0d_zero", i), {31'd0, ex_mem_zero}, {31'd0, v[i].zero});
      chk($sformatf("vec%0d_dest", i), {27'd0, ex_mem_dest_reg}, {27'd0, v[i].dest});
      chk($sformatf("vec%0d_ctrl", i), {27'd0, ex_mem_wb, ex_mem_mem}, {27'd0, v[i].wb, v[i].mem});
      chk($sformatf("vec%0d_rd2", i), ex_mem_readdat2, v[i].b);
    end
    // add $3,$1,$2 then sub $5,$3,$1 with a stale rs operand
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h11121951, 32'h23938222, 32'h1820, 5'd1, 5'd2, 5'd3);
    step();
`ifdef EXECUTE_FWD_EN
    wb_reg_write = 1'b1;
    wb_write_reg_location = 5'd3;
    mem_wb_write_data = 32'hDEADBEEF;
`endif
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h11121951, 32'h2822, 5'd3, 5'd1, 5'd5);
    step();
`ifdef EXECUTE_FWD_EN
    chk("fwd_exmem", ex_mem_alu_result, 32'h23938222);
    wb_write_reg_location = 5'd1;
    mem_wb_write_data = 32'd5;
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h7, 32'h3020, 5'd1, 5'd1, 5'd6);
    step();
    chk("fwd_memwb", ex_mem_alu_result, 32'd10);
    chk("fwd_rd2", ex_mem_readdat2, 32'd5);
    wb_reg_write = 1'b0;
`else
    chk("nofwd", ex_mem_alu_result, 32'hEEEDE6AF);
`endif
    run_multu(32'h00010000, 32'h00010000);
    // reset in the middle of a multiply
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h00010000, 32'h00010000, 32'h00000019, 5'd1, 5'd2, 5'd0);
    repeat (11) @(posedge clk);
    #2;
    chk("pre_rst_stall", {31'd0, ex_stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, ex_stall}, 32'd0);
    chk("mid_rst_outs", ex_mem_alu_result | ex_mem_add_result | ex_mem_readdat2 |
        {22'd0, ex_mem_wb, ex_mem_mem, ex_mem_dest_reg} | {31'd0, ex_mem_zero}, 32'd0);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h00000010, 5'd0, 5'd0, 5'd7);
    step();
    rst = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    chk("rst_mfhi", ex_mem_alu_result, 32'd0);
    chk("rst_mfhi_stall", {31'd0, ex_stall}, 32'd0);
    for (int i = 0; i < 3; i++) run_multu($urandom, $urandom);
    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      logic src;
      logic rdst;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] se;
      logic [31:0] npc;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [1:0] wb;
      logic [2:0] mem;
      logic [31:0] exp;
      op = 2'($urandom_range(0, 3));
      src = 1'($urandom);
      rdst = 1'($urandom);
      a = $urandom;
      b = $urandom;
      se = $urandom;
      if (op == 2'b10) se[5:0] = fl[$urandom_range(0, 10)];
      npc = $urandom;
      rt = 5'($urandom);
      rd = 5'($urandom);
      wb = {1'b0, 1'($urandom)};
      mem = 3'($urandom);
      exp = ref_alu(op, src, a, b, se);
      drive(wb, mem, {rdst, op, src}, npc, a, b, se, 5'd0, rt, rd);
      step();
      chk("rnd_res", ex_mem_alu_result, exp);
      chk("rnd_zero", {31'd0, ex_mem_zero}, {31'd0, exp == 32'd0});
      chk("rnd_addr", ex_mem_add_result, npc + (se << 2));
      chk("rnd_dest", {27'd0, ex_mem_dest_reg}, {27'd0, rdst ? rd : rt});
      chk("rnd_ctrl", {27'd0, ex_mem_wb, ex_mem_mem}, {27'd0, wb, mem});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
